mem_stage_lsu: RTL

- MEM-stage load/store unit. Sits directly downstream of the EX/MEM pipeline register and consumes its ALU result (address), store data and memory control fields.
- Drives a valid/ready data-memory bus and returns an aligned, extended load value to the MEM/WB register.
- Raises a stall to freeze the upstream pipeline registers until the access completes.
- Includes a bus-timeout watchdog.

---
 rtl/mem_stage_lsu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
// Turns the EX/MEM load/store control into one valid/ready data-memory access.
// It holds the upstream pipeline in a stall until the access completes.
// Load data is lane-extracted and extended before it reaches MEM/WB.
// A watchdog aborts any access that the bus leaves unanswered too long.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_ready_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [3:0]    wstrb_r;
  logic          we_r;
  logic [2:0]    funct3_r;
  logic [31:0]   load_data_r;
  logic          err_r;
  logic [CW-1:0] cnt_r;

  logic          op_s;
  logic          misaligned_s;
  logic [3:0]    wstrb_s;
  logic [31:0]   wdata_s;

  // Byte/half selection by the latched lane, then sign or zero extension.
  // Unlisted encodings, including the illegal load codes, pass the word through.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Decode the op, check alignment, and build the store lanes from the live EX/MEM fields.
  always_comb begin
    op_s    = mem_read_i | mem_write_i;
    wstrb_s = 4'b1111;
    wdata_s = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        misaligned_s = 1'b0;
        wstrb_s      = 4'b0001 << addr_i[1:0];
        wdata_s      = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        misaligned_s = addr_i[0];
        wstrb_s      = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{store_data_i[15:0]}};
      end
      default: begin
        misaligned_s = (addr_i[1:0] != 2'b00);
        wstrb_s      = 4'b1111;
        wdata_s      = store_data_i;
      end
    endcase
    misaligned_s = misaligned_s & op_s;
  end

  // Access sequencing: latch the request and drive the bus handshake.
  // Capture load data or abort on timeout, then release the pipeline for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'b0000;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      load_data_r <= 32'h0000_0000;
      err_r       <= 1'b0;
      cnt_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (op_s && !misaligned_s) begin
            state_r  <= REQ;
            addr_r   <= addr_i;
            wdata_r  <= wdata_s;
            wstrb_r  <= mem_write_i ? wstrb_s : 4'b0000;
            we_r     <= mem_write_i;
            funct3_r <= funct3_i;
            cnt_r    <= '0;
          end
        end
        REQ: begin
          if (bus_ready_i) begin
            cnt_r   <= '0;
            state_r <= we_r ? DONE : WAIT_R;
          end else if (cnt_r == TO_LAST) begin
            state_r     <= DONE;
            err_r       <= 1'b1;
            load_data_r <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WAIT_R: begin
          if (bus_rvalid_i) begin
            load_data_r <= extract_load(funct3_r, addr_r[1:0], bus_rdata_i);
            state_r     <= DONE;
          end else if (cnt_r == TO_LAST) begin
            state_r     <= DONE;
            err_r       <= 1'b1;
            load_data_r <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req_o    = (state_r == REQ);
  assign bus_we_o     = we_r;
  assign bus_addr_o   = {addr_r[31:2], 2'b00};
  assign bus_wdata_o  = wdata_r;
  assign bus_wstrb_o  = wstrb_r;
  assign load_data_o  = load_data_r;
  assign bus_err_o    = err_r;
  // Gating with reset keeps the stall low while reset is asserted, even if an op is still presented.
  assign stall_o      = reset & op_s & ~misaligned_s & (state_r != DONE);
  assign misaligned_o = misaligned_s & (state_r == IDLE);

endmodule
